cipher_output_buffer: RTL and testbench

- Terminal stage after the final (ROUND = 10) cipher round.
- Captures each ciphertext block presented on the round pipeline's tx_en/state outputs into a DEPTH-entry FIFO, then delivers it to the host side over a valid/ready handshake.
- The round pipeline has no backpressure, so this block absorbs bursts, reports fill level and flags dropped blocks.

---
 rtl/cipher_output_buffer.sv | 100 ++++++++++
 tb/tb_cipher_output_buffer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cipher_output_buffer.sv
// Output FIFO for the final cipher round: buffers ciphertext blocks for a valid/ready host port.
// Optional drop counter output o_drop_cnt is enabled by defining CIPHER_OUT_DROP_CNT_EN.
module cipher_output_buffer #(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           i_tx_en,
  input  logic [127:0]   i_state,
  input  logic           i_ready,
  input  logic           i_clear_ovf,
  output logic           o_valid,
  output logic [127:0]   o_state,
  output logic [CW-1:0]  o_count,
  output logic           o_full,
  output logic           o_overflow
`ifdef CIPHER_OUT_DROP_CNT_EN
  ,
  output logic [7:0]     o_drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [127:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic w_pop;
  logic w_push;
  logic w_drop;

  assign o_valid    = (r_count != '0);
  assign o_full     = (r_count == CW'(DEPTH));
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_state    = o_valid ? r_mem[r_rd_ptr] : '0;

  // A full FIFO still accepts a block when the host drains an entry on the same edge.
  assign w_pop  = o_valid && i_ready;
  assign w_push = i_tx_en && (!o_full || w_pop);
  assign w_drop = i_tx_en && o_full && !w_pop;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_state;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Setting on a drop takes priority over a coincident clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (i_clear_ovf) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef CIPHER_OUT_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  assign o_drop_cnt = r_drop_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_drop_cnt <= '0;
    end else if (i_clear_ovf) begin
      r_drop_cnt <= {7'd0, w_drop};
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cipher_output_buffer.sv
// Directed bench for cipher_output_buffer (DEPTH = 4); drop counter checks run when
// CIPHER_OUT_DROP_CNT_EN is defined.
module tb_cipher_output_buffer;

  logic         clock;
  logic         reset;
  logic         txEn;
  logic [127:0] stateIn;
  logic         ready;
  logic         clearOvf;
  logic         valid;
  logic [127:0] stateOut;
  logic [2:0]   count;
  logic         full;
  logic         overflow;
`ifdef CIPHER_OUT_DROP_CNT_EN
  logic [7:0]   dropCnt;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  cipher_output_buffer #(.DEPTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .i_tx_en     (txEn),
    .i_state     (stateIn),
    .i_ready     (ready),
    .i_clear_ovf (clearOvf),
    .o_valid     (valid),
    .o_state     (stateOut),
    .o_count     (count),
    .o_full      (full),
`ifdef CIPHER_OUT_DROP_CNT_EN
    .o_drop_cnt  (dropCnt),
`endif
    .o_overflow  (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(input logic t, input logic [127:0] s, input logic r, input logic c);
    txEn     = t;
    stateIn  = s;
    ready    = r;
    clearOvf = c;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  localparam logic [127:0] BLOCK_A = 128'h00112233445566778899aabbccddeeff;

  initial begin
    reset    = 1'b0;
    txEn     = 1'b0;
    stateIn  = '0;
    ready    = 1'b0;
    clearOvf = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_state", stateOut, 0);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_ovf", overflow, 0);
    reset = 1'b1;

    // single block in and out
    applyStimulus(1, BLOCK_A, 0, 0);
    checkOutput("one_valid", valid, 1);
    checkOutput("one_state", stateOut, BLOCK_A);
    checkOutput("one_count", count, 1);
    applyStimulus(0, '0, 1, 0);
    checkOutput("one_pop_valid", valid, 0);
    checkOutput("one_pop_state", stateOut, 0);
    checkOutput("one_pop_count", count, 0);

    // fill to full then drop block 5
    for (int i = 1; i <= 4; i++) applyStimulus(1, 128'(i), 0, 0);
    checkOutput("fill_full", full, 1);
    checkOutput("fill_count", count, 4);
    checkOutput("fill_ovf", overflow, 0);
    applyStimulus(1, 128'd5, 0, 0);
    checkOutput("drop_ovf", overflow, 1);
    checkOutput("drop_count", count, 4);
    checkOutput("drop_head", stateOut, 1);
    applyStimulus(0, '0, 0, 1);
    checkOutput("clr_ovf", overflow, 0);

    // full with push and pop together: block 6 accepted
    applyStimulus(1, 128'd6, 1, 0);
    checkOutput("pp_count", count, 4);
    checkOutput("pp_ovf", overflow, 0);
    checkOutput("pp_head", stateOut, 2);
    applyStimulus(0, '0, 1, 0);
    checkOutput("drain_3", stateOut, 3);
    applyStimulus(0, '0, 1, 0);
    checkOutput("drain_4", stateOut, 4);
    applyStimulus(0, '0, 1, 0);
    checkOutput("drain_6", stateOut, 6);
    checkOutput("drain_cnt1", count, 1);
    applyStimulus(0, '0, 1, 0);
    checkOutput("drain_empty", valid, 0);
    checkOutput("drain_cnt0", count, 0);

    // streaming push/pop across pointer wrap
    applyStimulus(1, 128'h100, 1, 0);
    checkOutput("stream_first", stateOut, 128'h100);
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1, 128'h100 + 128'(i), 1, 0);
      checkOutput("stream_count", count, 1);
      checkOutput("stream_state", stateOut, 128'h100 + 128'(i));
      checkOutput("stream_ovf", overflow, 0);
    end
    applyStimulus(0, '0, 1, 0);
    checkOutput("stream_end", count, 0);

    // clear coinciding with a drop keeps overflow set
    for (int i = 0; i < 4; i++) applyStimulus(1, 128'h200 + 128'(i), 0, 0);
    applyStimulus(1, 128'h2ff, 0, 0);
    checkOutput("ovf_set", overflow, 1);
    applyStimulus(1, 128'h2fe, 0, 1);
    checkOutput("ovf_clr_drop", overflow, 1);
    applyStimulus(0, '0, 0, 1);
    checkOutput("ovf_clr", overflow, 0);
    checkOutput("ovf_head", stateOut, 128'h200);

    // asynchronous reset mid-cycle with 3 entries
    applyStimulus(0, '0, 1, 0);
    checkOutput("pre_rst_count", count, 3);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("arst_valid", valid, 0);
    checkOutput("arst_count", count, 0);
    checkOutput("arst_full", full, 0);
    checkOutput("arst_state", stateOut, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    applyStimulus(1, 128'h300, 0, 0);
    checkOutput("post_rst_count", count, 1);
    checkOutput("post_rst_state", stateOut, 128'h300);
    applyStimulus(0, '0, 1, 0);

`ifdef CIPHER_OUT_DROP_CNT_EN
    // drop counter saturation and clear
    checkOutput("dc_zero", dropCnt, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 128'h400 + 128'(i), 0, 0);
    applyStimulus(1, 128'h4ff, 0, 0);
    checkOutput("dc_one", dropCnt, 1);
    for (int i = 1; i < 300; i++) applyStimulus(1, 128'h4ff, 0, 0);
    checkOutput("dc_sat", dropCnt, 255);
    checkOutput("dc_head", stateOut, 128'h400);
    applyStimulus(1, 128'h4ff, 0, 1);
    checkOutput("dc_clr_drop", dropCnt, 1);
    applyStimulus(0, '0, 0, 1);
    checkOutput("dc_clr", dropCnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
